// File: rtl/i2s_rx_dma_ctrl.sv
// I2S receive DMA: drains the RX FIFO in bursts into a circular word buffer
// through a single-beat write master, with sticky half/wrap interrupt flags.
module i2s_rx_dma_ctrl #(
  parameter int AW = 4,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic [31:0]   start_addr,
  input  logic [IW-1:0] buf_words,
  input  logic [AW-1:0] burst_len,
  input  logic [AW-1:0] fifo_level,
  input  logic          fifo_empty,
  input  logic [31:0]   fifo_rdata,
  output logic          fifo_rd,
  output logic          m_req,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_ack,
  input  logic [1:0]    irq_clr,
  output logic          half_flag,
  output logic          wrap_flag,
  output logic [IW-1:0] word_idx,
  output logic          busy
);

  // Write handshake: m_req is valid, m_ack is ready; a word transfers on a
  // rising edge where both are high, and m_req/m_addr/m_wdata hold until then.
  typedef enum logic [1:0] {IDLE, POP, REQ} state_e;

  localparam logic [AW-1:0] CNT_ONE = AW'(1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          half_q, half_d;
  logic          wrap_q, wrap_d;

  logic [AW-1:0] bl;
  logic [IW-1:0] bw;
  logic [IW-1:0] idx_next;
  logic          at_end;
  logic          hit_half;

  assign bl = (burst_len == '0) ? CNT_ONE : burst_len;
  assign bw = (buf_words == '0) ? IDX_ONE : buf_words;

  // >= rather than == so a ring shrunk below the current index still wraps.
  assign at_end   = (idx_q >= (bw - IDX_ONE));
  assign idx_next = at_end ? '0 : (idx_q + IDX_ONE);
  assign hit_half = (idx_next == (bw >> 1)) && (bw[IW-1:1] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    half_d  = half_q & ~irq_clr[0];
    wrap_d  = wrap_q & ~irq_clr[1];
    fifo_rd = 1'b0;
    m_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en) begin
          idx_d = '0;
        end else if (fifo_level >= bl) begin
          cnt_d   = bl;
          state_d = POP;
        end else if (flush && !fifo_empty) begin
          cnt_d   = fifo_level;
          state_d = POP;
        end
      end
      POP: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          fifo_rd = 1'b1;
          wdata_d = fifo_rdata;
          state_d = REQ;
        end
      end
      REQ: begin
        m_req = 1'b1;
        if (m_ack) begin
          idx_d = idx_next;
          cnt_d = cnt_q - CNT_ONE;
          if (hit_half) half_d = 1'b1;
          if (at_end) wrap_d = 1'b1;
          state_d = ((cnt_q != CNT_ONE) && en) ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      half_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      half_q  <= half_d;
      wrap_q  <= wrap_d;
    end
  end

  assign m_addr    = {start_addr[31:2], 2'b00} + (32'(idx_q) << 2);
  assign m_wdata   = wdata_q;
  assign word_idx  = idx_q;
  assign half_flag = half_q;
  assign wrap_flag = wrap_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_rx_dma_ctrl.sv
// Bench for i2s_rx_dma_ctrl: FIFO and write-slave models plus a ring-buffer
// reference that predicts every write address, data word, index and flag.
module tb_i2s_rx_dma_ctrl;
  localparam int AW = 4;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic [31:0]   start_addr;
  logic [IW-1:0] buf_words;
  logic [AW-1:0] burst_len;
  logic [AW-1:0] fifo_level;
  logic          fifo_empty;
  logic [31:0]   fifo_rdata;
  logic          fifo_rd;
  logic          m_req;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic          m_ack;
  logic [1:0]    irq_clr;
  logic          half_flag;
  logic          wrap_flag;
  logic [IW-1:0] word_idx;
  logic          busy;

  i2s_rx_dma_ctrl #(.AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .start_addr(start_addr), .buf_words(buf_words), .burst_len(burst_len),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .irq_clr(irq_clr), .half_flag(half_flag),
    .wrap_flag(wrap_flag), .word_idx(word_idx), .busy(busy)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- FIFO and write-slave models ----------------
  logic [31:0] fifo_q[$];
  int ack_delay = 0;
  int req_age = 0;

  // Slave accepts a request once it has been pending for more than ack_delay cycles.
  assign m_ack = m_req && (req_age > ack_delay);

  function automatic void sync_fifo();
    fifo_level = AW'((fifo_q.size() > 15) ? 15 : fifo_q.size());
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] exp_q[$];      // words popped, awaiting their write
  int          m_idx = 0;
  logic        m_half = 1'b0;
  logic        m_wrap = 1'b0;
  int          n_pop = 0;
  int          n_wr = 0;
  int          cyc = 0;
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          wr_cyc_log[$];
  int          hold_log[$];

  initial begin : monitor
    logic        pop_now;
    logic        acc;
    logic        prev_pop;
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    int          hold_cnt;
    int          bw_e;
    int          new_idx;
    logic        wrapped;
    logic        set_h;
    pop_now = 1'b0; prev_pop = 1'b0; prev_hold = 1'b0; hold_cnt = 0;
    prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        m_idx = 0; m_half = 1'b0; m_wrap = 1'b0;
        pop_now = 1'b0; prev_pop = 1'b0; prev_hold = 1'b0; hold_cnt = 0;
      end else begin
        pop_now = fifo_rd;
        acc     = m_req && m_ack;
        check("word_idx", word_idx, m_idx);
        check("half_flag", half_flag, m_half);
        check("wrap_flag", wrap_flag, m_wrap);
        check("rd_req_overlap", fifo_rd && m_req, 0);
        check("rd_back_to_back", pop_now && prev_pop, 0);
        if (m_req && prev_hold) begin
          check("addr_stable", m_addr, prev_addr);
          check("data_stable", m_wdata, prev_data);
        end
        if (m_req) hold_cnt++;
        if (pop_now) begin
          check("pop_when_empty", fifo_empty, 0);
          if (fifo_q.size() != 0) exp_q.push_back(fifo_q[0]);
          n_pop++;
        end
        if (acc) begin
          bw_e = (buf_words == 0) ? 1 : int'(buf_words);
          check("m_addr", m_addr, {start_addr[31:2], 2'b00} + 32'(m_idx * 4));
          check("write_has_pop", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("m_wdata", m_wdata, exp_q.pop_front());
          wr_addr_log.push_back(m_addr);
          wr_data_log.push_back(m_wdata);
          wr_cyc_log.push_back(cyc);
          hold_log.push_back(hold_cnt);
          hold_cnt = 0;
          wrapped = (m_idx >= bw_e - 1);
          new_idx = wrapped ? 0 : m_idx + 1;
          set_h   = (new_idx == bw_e / 2) && (bw_e >= 2);
          m_half  = set_h | (m_half & ~irq_clr[0]);
          m_wrap  = wrapped | (m_wrap & ~irq_clr[1]);
          m_idx   = new_idx;
          n_wr++;
        end else begin
          m_half = m_half & ~irq_clr[0];
          m_wrap = m_wrap & ~irq_clr[1];
          if (!en && !busy) m_idx = 0;
        end
        prev_pop  = pop_now;
        prev_hold = m_req && !acc;
        prev_addr = m_addr;
        prev_data = m_wdata;
      end
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
      sync_fifo();
      req_age = m_req ? req_age + 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    if (fifo_q.size() < 15) fifo_q.push_back(d);
    sync_fifo();
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete(); hold_log.delete();
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 1000) begin
      step(1);
      t++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d_words[4];
  int p0;
  int w0;
  int t;

  initial begin : main
    rst = 1'b1; en = 1'b0; flush = 1'b0; irq_clr = 2'b00;
    start_addr = 32'h0000_1003; buf_words = IW'(8); burst_len = AW'(4);
    sync_fifo();
    step(3);
    check("rst_m_req", m_req, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_word_idx", word_idx, 0);
    check("rst_flags", {half_flag, wrap_flag}, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_m_addr", m_addr, 32'h0000_1000);
    start_addr = 32'h0000_1000;
    rst = 1'b0;
    step(2);

    // Burst 1: four preloaded words, zero-wait ack.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      d_words[i] = 32'hD000_0000 + 32'(i);
      push_word(d_words[i]);
    end
    en = 1'b1;
    step(2);
    wait_idle("s1");
    check("s1_writes", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("s1_addr", wr_addr_log[i], 32'h1000 + 32'(4 * i));
        check("s1_data", wr_data_log[i], d_words[i]);
        if (i > 0) check("s1_spacing", wr_cyc_log[i] - wr_cyc_log[i-1], 2);
      end
    end
    check("s1_half", half_flag, 1);
    check("s1_idx", word_idx, 4);

    // Burst 2: upper half, wraps to index 0.
    clear_logs();
    for (int i = 0; i < 4; i++) push_word($urandom());
    step(2);
    wait_idle("s2");
    check("s2_writes", wr_addr_log.size(), 4);
    if (wr_addr_log.size() == 4)
      for (int i = 0; i < 4; i++) check("s2_addr", wr_addr_log[i], 32'h1010 + 32'(4 * i));
    check("s2_idx", word_idx, 0);
    check("s2_wrap", wrap_flag, 1);
    irq_clr = 2'b01;
    step(1);
    irq_clr = 2'b00;
    step(1);
    check("s2_clr_half", half_flag, 0);
    check("s2_keep_wrap", wrap_flag, 1);

    // Burst 3: clear both flags on the very ack that sets half.
    for (int i = 0; i < 4; i++) push_word($urandom());
    t = 0;
    while (!(m_req && word_idx == 3) && t < 200) begin
      step(1);
      t++;
    end
    check("s3_reach_idx3", m_req && word_idx == 3, 1);
    irq_clr = 2'b11;
    step(1);
    irq_clr = 2'b00;
    wait_idle("s3");
    check("s3_half_set_wins", half_flag, 1);
    check("s3_wrap_cleared", wrap_flag, 0);
    check("s3_idx", word_idx, 4);

    // Slow slave: five-cycle request hold per word.
    clear_logs();
    ack_delay = 4;
    for (int i = 0; i < 4; i++) push_word($urandom());
    step(2);
    wait_idle("s4");
    check("s4_writes", hold_log.size(), 4);
    foreach (hold_log[i]) check("s4_hold", hold_log[i], 5);
    ack_delay = 0;

    // Short FIFO below burst length: idle without flush, drains with flush.
    burst_len = AW'(8);
    for (int i = 0; i < 3; i++) push_word($urandom());
    p0 = n_pop; w0 = n_wr;
    step(20);
    check("s5_noflush_pops", n_pop - p0, 0);
    check("s5_noflush_busy", busy, 0);
    flush = 1'b1;
    step(2);
    wait_idle("s5");
    check("s5_flush_pops", n_pop - p0, 3);
    check("s5_flush_writes", n_wr - w0, 3);
    flush = 1'b0;

    // Enable dropped while the second word of a burst awaits its ack.
    burst_len = AW'(4);
    ack_delay = 4;
    p0 = n_pop; w0 = n_wr;
    for (int i = 0; i < 4; i++) push_word($urandom());
    t = 0;
    while (!((n_pop - p0) == 2 && m_req) && t < 200) begin
      step(1);
      t++;
    end
    check("s6_in_second_req", m_req, 1);
    en = 1'b0;
    step(2);
    wait_idle("s6");
    step(3);
    check("s6_pops", n_pop - p0, 2);
    check("s6_writes", n_wr - w0, 2);
    check("s6_idx_cleared", word_idx, 0);
    fifo_q.delete();
    sync_fifo();

    // Asynchronous reset while a request is pending.
    ack_delay = 6;
    en = 1'b1;
    for (int i = 0; i < 4; i++) push_word($urandom());
    t = 0;
    while (!m_req && t < 50) begin
      step(1);
      t++;
    end
    check("s7_in_req", m_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("s7_m_req", m_req, 0);
    check("s7_fifo_rd", fifo_rd, 0);
    check("s7_flags", {half_flag, wrap_flag}, 0);
    check("s7_idx", word_idx, 0);
    check("s7_busy", busy, 0);
    step(1);
    rst = 1'b0;
    ack_delay = 0;
    clear_logs();
    push_word($urandom());
    step(2);
    wait_idle("s7");
    check("s7_restart_writes", wr_addr_log.size(), 4);
    if (wr_addr_log.size() != 0) check("s7_restart_addr", wr_addr_log[0], 32'h1000);

    // Randomized configurations, enable drops and flag clears.
    for (int it = 0; it < 40; it++) begin
      wait_idle("rnd");
      burst_len  = AW'($urandom_range(0, 6));
      buf_words  = IW'($urandom_range(0, 12));
      start_addr = $urandom();
      ack_delay  = $urandom_range(0, 3);
      flush      = ($urandom_range(0, 3) == 0);
      en         = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) push_word($urandom());
      for (int k = 0; k < int'($urandom_range(10, 60)); k++) begin
        irq_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        if ($urandom_range(0, 40) == 0) en = 1'b0;
        step(1);
      end
      irq_clr = 2'b00;
    end

    // Drain everything left; every popped word must have been written.
    en = 1'b1;
    flush = 1'b1;
    for (int r = 0; r < 20 && (fifo_q.size() != 0 || busy); r++) begin
      step(2);
      wait_idle("drain");
    end
    flush = 1'b0;
    step(2);
    check("drain_fifo_empty", fifo_q.size(), 0);
    check("drain_all_written", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
